my_mult_signed_pipe: RTL

Pipelined signed fixed-point multiplier with valid/ready flow control, selectable rounding and saturation, and overflow reporting. It replaces the purely combinational truncating multiplier in timing-critical datapaths such as CTLE/DFE tap products and channel-response convolution. Pipeline depth is set by parameter so the multiplier can be retimed against the emulator's target clock.

---
 rtl/my_fixed_pkg.sv | 24 ++
 rtl/my_fixed_resize.sv | 74 +++++++
 rtl/my_mult_signed_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/my_fixed_pkg.sv
// my_fixed_pkg
// Shared fixed-point helpers for the signed datapath blocks:
//   - rounding-mode constants (ROUND_TRUNC, ROUND_HALF_UP)
//   - saturation-mode constants (SAT_WRAP, SAT_CLAMP)
//   - fixed_min / fixed_max: signed range limits of a two's-complement width
package my_fixed_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    // Most negative value representable in a signed field of 'bits' bits.
    function automatic logic signed [63:0] fixed_min(input int bits);
        fixed_min = -(64'sd1 <<< (bits - 1));
    endfunction

    // Most positive value representable in a signed field of 'bits' bits.
    function automatic logic signed [63:0] fixed_max(input int bits);
        fixed_max = (64'sd1 <<< (bits - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/my_fixed_resize.sv
// my_fixed_resize
// Combinational signed fixed-point resize: re-aligns the binary point from
// in_point to out_point (optional half-up rounding when bits are dropped)
// and fits the value into out_bits (wrap or clamp), flagging overflow.
// Ports:
//   in  [in_bits]  : signed input value
//   out [out_bits] : resized signed value
//   ovf            : shifted value was outside the out_bits range
module my_fixed_resize
    import my_fixed_pkg::*;
#(
    parameter int in_bits    = 16,
    parameter int in_point   = 8,
    parameter int out_bits   = 8,
    parameter int out_point  = 4,
    parameter int round_mode = ROUND_HALF_UP,
    parameter int sat_mode   = SAT_CLAMP
) (
    input  logic signed [in_bits-1:0]  in,
    output logic signed [out_bits-1:0] out,
    output logic                       ovf
);

    localparam int RSHIFT = in_point - out_point;
    localparam int LSHIFT = (RSHIFT < 0) ? -RSHIFT : 0;
    // Wide enough for the rounding carry, any left shift and the range compare.
    localparam int EXT_BITS = in_bits + LSHIFT + out_bits + 2;

    localparam logic signed [EXT_BITS-1:0] C_MIN = EXT_BITS'(fixed_min(out_bits));
    localparam logic signed [EXT_BITS-1:0] C_MAX = EXT_BITS'(fixed_max(out_bits));

    logic signed [EXT_BITS-1:0] ext_s;
    logic signed [EXT_BITS-1:0] sh_s;

    assign ext_s = {{(EXT_BITS-in_bits){in[in_bits-1]}}, in};

    generate
        if (RSHIFT > 0) begin : g_rshift
            localparam logic signed [EXT_BITS-1:0] ONE = {{(EXT_BITS-1){1'b0}}, 1'b1};
            localparam logic signed [EXT_BITS-1:0] RND =
                (round_mode == ROUND_HALF_UP) ? (ONE <<< (RSHIFT - 1)) : {EXT_BITS{1'b0}};
            // Arithmetic shift floors toward -inf; the RND offset turns it into half-up.
            assign sh_s = (ext_s + RND) >>> RSHIFT;
        end else begin : g_lshift
            // Growing the fraction is lossless, so rounding never applies here.
            assign sh_s = ext_s <<< LSHIFT;
        end
    endgenerate

    // Range check and wrap/clamp selection.
    always_comb begin
        ovf = 1'b0;
        out = sh_s[out_bits-1:0];
        if (sh_s > C_MAX) begin
            ovf = 1'b1;
            if (sat_mode == SAT_CLAMP) begin
                out = C_MAX[out_bits-1:0];
            end else begin
                out = sh_s[out_bits-1:0];
            end
        end else if (sh_s < C_MIN) begin
            ovf = 1'b1;
            if (sat_mode == SAT_CLAMP) begin
                out = C_MIN[out_bits-1:0];
            end else begin
                out = sh_s[out_bits-1:0];
            end
        end else begin
            ovf = 1'b0;
            out = sh_s[out_bits-1:0];
        end
    end

endmodule

// File: rtl/my_mult_signed_pipe.sv
// my_mult_signed_pipe
// Pipelined signed fixed-point multiplier with valid/ready flow control.
// Stage 1 registers the full-width product, middle stages delay it, the final
// stage registers the resized (rounded/saturated) result. A single global
// stall (out_valid & ~out_ready) freezes every stage.
// Ports:
//   clk, rst (async, active high)
//   in_valid/in_ready, a, b       : operand handshake
//   out_valid/out_ready, c, ovf   : result handshake (ovf qualified by out_valid)
//   ovf_sticky, ovf_clr           : overflow history flag and its clear
module my_mult_signed_pipe
    import my_fixed_pkg::*;
#(
    parameter int a_bits     = 8,
    parameter int a_point    = 4,
    parameter int b_bits     = 8,
    parameter int b_point    = 4,
    parameter int c_bits     = 8,
    parameter int c_point    = 4,
    parameter int stages     = 2,
    parameter int round_mode = ROUND_HALF_UP,
    parameter int sat_mode   = SAT_CLAMP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [a_bits-1:0] a,
    input  logic signed [b_bits-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [c_bits-1:0] c,
    output logic                     ovf,
    output logic                     ovf_sticky,
    input  logic                     ovf_clr
);

    localparam int P_BITS = a_bits + b_bits;

    logic signed [P_BITS-1:0] prod_s;
    logic signed [P_BITS-1:0] rs_in_s;
    logic signed [c_bits-1:0] res_s;
    logic                     res_ovf_s;
    logic [stages-1:0]        vld_r;
    logic                     stall_s;
    logic                     last_vld_s;

    // Sign-extend both operands to the product width so the product is exact.
    assign prod_s = $signed({{b_bits{a[a_bits-1]}}, a}) * $signed({{a_bits{b[b_bits-1]}}, b});

    assign out_valid = vld_r[stages-1];
    assign stall_s   = out_valid & ~out_ready;
    assign in_ready  = ~stall_s;

    // Valid shift chain: bubbles advance whenever the pipe is not stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= {stages{1'b0}};
        end else if (!stall_s) begin
            vld_r[0] <= in_valid;
            for (int i = 1; i < stages; i++) begin
                vld_r[i] <= vld_r[i-1];
            end
        end
    end

    generate
        if (stages == 1) begin : g_single
            assign rs_in_s    = prod_s;
            assign last_vld_s = in_valid;
        end else begin : g_multi
            logic signed [P_BITS-1:0] prod_r [stages-1];

            // Product register followed by plain delay registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < stages - 1; i++) begin
                        prod_r[i] <= {P_BITS{1'b0}};
                    end
                end else if (!stall_s) begin
                    prod_r[0] <= prod_s;
                    for (int i = 1; i < stages - 1; i++) begin
                        prod_r[i] <= prod_r[i-1];
                    end
                end
            end

            assign rs_in_s    = prod_r[stages-2];
            assign last_vld_s = vld_r[stages-2];
        end
    endgenerate

    my_fixed_resize #(
        .in_bits   (P_BITS),
        .in_point  (a_point + b_point),
        .out_bits  (c_bits),
        .out_point (c_point),
        .round_mode(round_mode),
        .sat_mode  (sat_mode)
    ) u_resize (
        .in (rs_in_s),
        .out(res_s),
        .ovf(res_ovf_s)
    );

    // Result register: loads only real samples so c holds its last value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c   <= {c_bits{1'b0}};
            ovf <= 1'b0;
        end else if (!stall_s && last_vld_s) begin
            c   <= res_s;
            ovf <= res_ovf_s;
        end
    end

    // Overflow history; a set on this cycle's transfer beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule
